// File: rtl/gol_pkg.sv
// Shared definitions for the Game of Life generation-rate control path.
package gol_pkg;

  // Bit positions of the four push buttons inside btn_in
  localparam int BTN_RUN  = 0;
  localparam int BTN_STEP = 1;
  localparam int BTN_UP   = 2;
  localparam int BTN_DN   = 3;

  // Run/pause state of the generation controller
  typedef enum logic {
    PAUSED  = 1'b0,
    RUNNING = 1'b1
  } rate_state_t;

endpackage

// File: rtl/btn_debounce.sv
// One push button: two-flop synchroniser, counter-based debounce and a
// one-cycle press pulse on each debounced rising edge.
module btn_debounce
  import gol_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level_out,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES);

  logic          sync1_q;
  logic          sync2_q;
  logic          db_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  // Bring the raw asynchronous button into the clock domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Flip the debounced state only after DB_CYCLES consecutive disagreeing
  // samples; the press pulse is registered alongside the flip to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q    <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      if (sync2_q == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        db_q    <= sync2_q;
        cnt_q   <= '0;
        press_q <= sync2_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign level_out = db_q;
  assign press     = press_q;

endmodule

// File: rtl/gen_rate_ctrl.sv
// Generation-rate controller: debounced buttons drive a RUN/PAUSE machine
// with single step and a saturating speed ladder; emits gen_tick, a
// free-running prescaler and a heartbeat LED.
module gen_rate_ctrl
  import gol_pkg::*;
#(
  parameter int CNT_W     = 30,
  parameter int LVL_W     = 3,
  parameter int SHIFT_MIN = 20,
  parameter int INIT_LVL  = 4,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       btn_in,
  output logic             gen_tick,
  output logic             running,
  output logic [LVL_W-1:0] level,
  output logic [CNT_W-1:0] freq,
  output logic             led
);

  localparam int MAX_LVL = 2**LVL_W - 1;
  localparam int DIV_W   = SHIFT_MIN + MAX_LVL;
  localparam logic [LVL_W-1:0] LVL_TOP  = LVL_W'(MAX_LVL);
  localparam logic [LVL_W-1:0] LVL_INIT = LVL_W'(INIT_LVL);

  logic [3:0] btn_db;
  logic [3:0] btn_press;
  logic [3:0] btn_evt;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
      btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_btn (
        .clk       (clk),
        .rst       (rst),
        .raw       (btn_in[gi]),
        .level_out (btn_db[gi]),
        .press     (btn_press[gi])
      );
    end
  endgenerate

  // A press is only honoured while its debounced level is high
  assign btn_evt = btn_press & btn_db;

  rate_state_t      state_q;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_last;
  logic [CNT_W-1:0] freq_q;
  logic             run_prev_q;
  logic             tick_q;
  logic             led_q;
  logic             lvl_chg;
  logic             count_en;
  logic             expire;
  logic             step_ok;
  logic             tick_d;

  // Next speed level, period expiry and tick request for this cycle
  always_comb begin
    level_d = level_q;
    if (btn_evt[BTN_UP] && !btn_evt[BTN_DN] && level_q != LVL_TOP) begin
      level_d = level_q + LVL_W'(1);
    end else if (btn_evt[BTN_DN] && !btn_evt[BTN_UP] && level_q != '0) begin
      level_d = level_q - LVL_W'(1);
    end
    lvl_chg  = (level_d != level_q);
    // P(level)-1 is all ones shifted right by level
    div_last = {DIV_W{1'b1}} >> level_q;
    // The divider idles for the first RUNNING cycle, so the first tick
    // after resume lands P+1 cycles after running rises.
    count_en = (state_q == RUNNING) && run_prev_q;
    expire   = count_en && (div_q == div_last);
    step_ok  = btn_evt[BTN_STEP] && !btn_evt[BTN_RUN] && (state_q == PAUSED);
    tick_d   = expire || step_ok;
  end

  // RUN/PAUSE machine with level register, divider and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= PAUSED;
      level_q    <= LVL_INIT;
      div_q      <= '0;
      run_prev_q <= 1'b0;
      tick_q     <= 1'b0;
      led_q      <= 1'b0;
    end else begin
      run_prev_q <= (state_q == RUNNING);
      level_q    <= level_d;
      tick_q     <= tick_d;
      led_q      <= led_q ^ tick_d;
      if (btn_evt[BTN_RUN]) begin
        state_q <= (state_q == RUNNING) ? PAUSED : RUNNING;
        div_q   <= '0;
      end else if (lvl_chg || expire) begin
        div_q <= '0;
      end else if (count_en) begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

  // Free-running prescaler for the display logic
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freq_q <= '0;
    end else begin
      freq_q <= freq_q + CNT_W'(1);
    end
  end

  assign gen_tick = tick_q;
  assign running  = (state_q == RUNNING);
  assign level    = level_q;
  assign freq     = freq_q;
  assign led      = led_q;

endmodule

// File: doc/gen_rate_ctrl.md
# gen_rate_ctrl

Parametrised generation-rate controller for the Game of Life board top level. It debounces the four push buttons and runs a RUN/PAUSE state machine with single-step and up/down speed control. It emits a one-cycle `gen_tick` that advances the cell array, and exports the speed level and a free-running prescaler for the seven-segment and LED logic. It replaces the fixed switch-selected divider with a saturating, button-driven speed ladder and pause/step modes.

## Interface
- `CNT_W`, 30: width of free-running prescaler `freq`.
- `LVL_W`, 3: speed level width; `MAX_LVL = 2**LVL_W - 1`.
- `SHIFT_MIN`, 20: log2 of tick period at `MAX_LVL`; requires `SHIFT_MIN + MAX_LVL <= CNT_W`.
- `INIT_LVL`, 4: level loaded at reset; range 0..`MAX_LVL`.
- `DB_CYCLES`, 1_000_000: consecutive cycles a synchronised button must disagree with its debounced state before that state flips.
- `clk  in  1  system clock`
- `rst  in  1  reset; one clock; reset is asynchronous and active-high`
- `btn_in  in  4  raw asynchronous buttons, active-high: [0] run/pause toggle, [1] single step, [2] speed up, [3] speed down`
- `gen_tick  out  1  one-cycle generation advance pulse, registered`
- `running  out  1  1 = RUN state`
- `level  out  LVL_W  current speed level; higher level = faster`
- `freq  out  CNT_W  free-running prescaler, increments every cycle, wraps`
- `led  out  1  toggles on every gen_tick (heartbeat)`

## Operation
- Per button: 2-FF synchroniser, then debounce counter. The counter clears whenever the synchronised value equals the debounced state. When the counter reaches `DB_CYCLES`, the debounced state takes the synchronised value and the counter clears. A rising edge of the debounced state gives a one-cycle press pulse; release produces nothing.
- States: PAUSED (reset), RUNNING.
  - Run pulse: PAUSED <-> RUNNING.
  - Step pulse in PAUSED: `gen_tick` is high for exactly one cycle. Step pulse in RUNNING: ignored.
- Tick period `P(level) = 2**(SHIFT_MIN + MAX_LVL - level)` cycles.
  - Divider counter `div` (width `SHIFT_MIN + MAX_LVL`) runs only in RUNNING.
  - When `div == P-1`: `gen_tick` is high next cycle and `div` goes to 0.
  - `div` is cleared on entering RUNNING, on entering PAUSED, and on any level change. The first tick after resume or a speed change therefore comes a full new period later.
- Speed-up pulse: `level + 1`, saturating at `MAX_LVL`. Speed-down pulse: `level - 1`, saturating at 0. Both take effect in either state.
- Simultaneous pulses:
  - Up and down together: level unchanged and `div` not cleared.
  - Run and step together: run toggle applies and step is ignored.
  - A speed change in the same cycle as a period expiry: the tick still issues and `div` restarts under the new level.
- `led` toggles on every `gen_tick`.

## Timing
- Reset values: `gen_tick` 0, `running` 0, `level` = `INIT_LVL`, `freq` 0, `led` 0. All debounced states and counters are 0, `div` is 0.
- Deasserting `rst` mid-operation resumes from these values; it produces no spurious pulse, even if a button is held (a held button is debounced afresh).
- Button latency: a clean raw transition held steady gives a press pulse exactly `DB_CYCLES + 3` rising edges after the first sampling edge. The effect on `running` or `level` is visible 1 cycle later.
- Step: `gen_tick` is asserted in the cycle after the step pulse.
- RUNNING steady state: `gen_tick` pulses are exactly `P(level)` cycles apart. The first pulse comes `P + 1` cycles after `running` rises.
- A glitch shorter than `DB_CYCLES` synchronised cycles produces no pulse.

## Structure
- Package `gol_pkg`:
  - button index constants `BTN_RUN=0`, `BTN_STEP=1`, `BTN_UP=2`, `BTN_DN=3`;
  - state enum `rate_state_t {PAUSED, RUNNING}`.
- One sub-module, `btn_debounce` (param `DB_CYCLES`; ports `clk`, `rst`, `raw`, `level_out`, `press`), instantiated 4× via generate.
- The top contains the FSM, level register, divider, prescaler and `led`.

## Test plan
Bench parameters: `DB_CYCLES=4`, `LVL_W=2`, `SHIFT_MIN=2`, `INIT_LVL=1`, `CNT_W=8`.
- Reset, no buttons -> `running=0`, `level=1`, no `gen_tick` for 200 cycles; `freq` counts 0..255 and wraps to 0.
- `btn_in[0]` high for 20 cycles -> `running=1` at edge 8 after assertion. Ticks follow every 16 cycles (`P(1)=2**4`) and `led` toggles on each.
- While paused, 3 step presses -> exactly 3 one-cycle `gen_tick` pulses, each 1 cycle after its press pulse. A step press while running -> no extra tick.
- Speed-up pressed 4× from level 1 -> level 2, 3, 3, 3 (saturates); tick spacing becomes 4. Speed-down 5× -> level reaches 0 and holds; spacing becomes 32.
- 3-cycle glitch on `btn_in[2]` -> no level change. `btn_in[2]` and `btn_in[3]` pressed together -> level unchanged and tick phase undisturbed.
- Assert `rst` mid-period while `btn_in[0]` is held -> outputs return to reset values immediately. After release of `rst`, the held button yields one press pulse at `DB_CYCLES + 3` cycles.
